mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_read_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter: N_REQ requesters share one memory read port,
// with one burst outstanding at a time (IDLE -> ADDR -> DATA).
module mem_read_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_araddr,
    input  logic [N_REQ*LEN_WIDTH-1:0]    req_arlen,
    input  logic [N_REQ-1:0]              req_arvalid,
    output logic [N_REQ-1:0]              req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [N_REQ-1:0]              req_rvalid,
    input  logic [N_REQ-1:0]              req_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_WIDTH-1:0]          m_arlen,
    output logic                          m_arvalid,
    output logic [3:0]                    m_arid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          busy
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH:0]     cnt_q, cnt_d;
    logic [GW-1:0]          pick;
    logic                   found;
    logic                   beat;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % N_REQ;
            if (!found && req_arvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        m_arvalid    = 1'b0;
        m_araddr     = addr_q;
        m_arlen      = len_q;
        m_arid       = 4'(grant_q);
        m_rready     = 1'b0;
        req_arready  = '0;
        req_rvalid   = '0;
        req_rdata    = m_rdata;
        busy         = (state_q != IDLE);
        beat         = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    addr_d  = req_araddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d   = req_arlen[int'(pick)*LEN_WIDTH +: LEN_WIDTH];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    req_arready[grant_q] = 1'b1;
                    // A zero-length request still moves one beat.
                    cnt_d   = (len_q == '0) ? (LEN_WIDTH+1)'(1) : {1'b0, len_q};
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rready            = req_rready[grant_q];
                req_rvalid[grant_q] = m_rvalid;
                beat                = m_rvalid && req_rready[grant_q];
                if (beat) begin
                    cnt_d = cnt_q - (LEN_WIDTH+1)'(1);
                    if (cnt_q == (LEN_WIDTH+1)'(1)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: requesters and memory are modelled here,
// expected grants/beats go to a scoreboard checked by a separate negedge monitor.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*AW-1:0]   req_araddr;
    logic [N*LW-1:0]   req_arlen;
    logic [N-1:0]      req_arvalid;
    logic [N-1:0]      req_arready;
    logic [DW-1:0]     req_rdata;
    logic [N-1:0]      req_rvalid;
    logic [N-1:0]      req_rready;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic              m_arvalid;
    logic [3:0]        m_arid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic              m_rvalid;
    logic              m_rready;
    logic              busy;

    mem_read_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
        .req_arready(req_arready), .req_rdata(req_rdata), .req_rvalid(req_rvalid),
        .req_rready(req_rready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] wq[$];
    int            checks   = 0;
    int            failures = 0;
    int            m_last   = N - 1;
    int            exp_id   = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [LW-1:0] exp_len  = '0;
    bit            in_burst = 1'b0;
    bit            granted[N];
    bit            pending[N];
    logic [AW-1:0] cur_addr[N];
    logic [LW-1:0] cur_len[N];
    logic [N-1:0]  arv_prev_neg = '0;
    logic          marv_prev    = 1'b0;
    int            burst_taken  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester after 'last', wrapping.
    function automatic int rr(input int last, input logic [N-1:0] p);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_len();
        int r;
        r = $urandom_range(0, 63);
        if (r == 0) return 8'hFF;
        if (r < 8)  return 8'h00;
        return LW'($urandom_range(1, 6));
    endfunction

    task automatic put_reqs();
        for (int i = 0; i < N; i++) begin
            req_araddr[i*AW +: AW] = cur_addr[i];
            req_arlen[i*LW +: LW]  = cur_len[i];
            req_arvalid[i]         = pending[i];
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int           g;
        logic [N-1:0] oh;
        beat_t        b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_arvalid && !marv_prev) begin
                    g = rr(m_last, arv_prev_neg);
                    if (g < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_grant: got arid %0d expected no grant at %0t", m_arid, $time);
                    end else begin
                        m_last     = g;
                        exp_id     = g;
                        exp_addr   = cur_addr[g];
                        exp_len    = cur_len[g];
                        granted[g] = 1'b1;
                    end
                end
                oh = '0;
                oh[exp_id] = 1'b1;
                if (m_arvalid) begin
                    chk("arid", m_arid, exp_id);
                    chk("araddr", m_araddr, exp_addr);
                    chk("arlen", m_arlen, exp_len);
                end
                chk("arready", req_arready, (m_arvalid && m_arready) ? oh : '0);
                chk("busy", busy, m_arvalid || in_burst);
                if (in_burst) begin
                    chk("rvalid_route", req_rvalid, m_rvalid ? oh : '0);
                    chk("m_rready", m_rready, req_rready[exp_id]);
                end else if (m_rvalid) begin
                    chk("stray_rvalid", req_rvalid, 0);
                    chk("stray_rready", m_rready, 0);
                end
                for (int i = 0; i < N; i++) begin
                    if (req_rvalid[i] && req_rready[i]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat: got beat on req %0d expected none at %0t", i, $time);
                        end else begin
                            b = exp_q.pop_front();
                            chk("beat_req", i, b.idx);
                            chk("beat_data", req_rdata, b.data);
                        end
                    end
                end
            end
            marv_prev    = m_arvalid;
            arv_prev_neg = req_arvalid;
        end
    end

    // Stimulus: requesters and memory
    initial begin
        logic [N-1:0]  arh;
        logic          mar_hs, r_hs;
        int            n, stray_cnt;
        bit            rst_done, stop_req, any_pend, done;
        logic [DW-1:0] w;
        beat_t         nb;
        stray_cnt = 0;
        rst_done  = 1'b0;
        done      = 1'b0;
        rst_n      = 1'b0;
        req_rready = '1;
        m_arready  = 1'b1;
        m_rvalid   = 1'b1;
        m_rdata    = '0;
        for (int i = 0; i < N; i++) begin
            cur_addr[i] = 32'h1000 * (i + 1);
            cur_len[i]  = 8'd4;
            pending[i]  = 1'b1;
            granted[i]  = 1'b0;
        end
        put_reqs();
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_arvalid", m_arvalid, 0);
        chk("reset_rready", m_rready, 0);
        chk("reset_arready", req_arready, 0);
        chk("reset_rvalid", req_rvalid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(negedge clk);
            arh    = req_arvalid & req_arready;
            mar_hs = m_arvalid & m_arready;
            r_hs   = m_rvalid & m_rready;
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            stop_req = (cyc >= 4000);
            any_pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (pending[i] && granted[i] && (arh[i] || $urandom_range(0, 3) == 0)) begin
                    // may drop before the address handshake: the latched request must still run
                    pending[i]  = 1'b0;
                    granted[i]  = 1'b0;
                    cur_addr[i] = $urandom;
                end else if (!pending[i] && !stop_req && $urandom_range(0, 5) == 0) begin
                    pending[i]  = 1'b1;
                    cur_addr[i] = $urandom;
                    cur_len[i]  = rand_len();
                end
                req_rready[i] = ($urandom_range(0, 9) < 7);
                any_pend |= pending[i];
            end
            put_reqs();

            if (in_burst && r_hs) begin
                void'(wq.pop_front());
                burst_taken++;
            end
            if (mar_hs) begin
                n           = (exp_len == 0) ? 1 : int'(exp_len);
                in_burst    = 1'b1;
                burst_taken = 0;
                for (int k = 0; k < n; k++) begin
                    w       = $urandom;
                    nb.idx  = exp_id;
                    nb.data = w;
                    wq.push_back(w);
                    exp_q.push_back(nb);
                end
            end
            if (in_burst && wq.size() == 0) in_burst = 1'b0;

            if (!rst_done && cyc > 1500 && in_burst && burst_taken >= 2 && wq.size() >= 1) begin
                rst_done = 1'b1;
                rst_n    = 1'b0;
                m_rvalid = 1'b1;
                m_rdata  = $urandom;
                #1;
                chk("midrst_busy", busy, 0);
                chk("midrst_arvalid", m_arvalid, 0);
                chk("midrst_rready", m_rready, 0);
                chk("midrst_arready", req_arready, 0);
                chk("midrst_rvalid", req_rvalid, 0);
                exp_q.delete();
                wq.delete();
                in_burst  = 1'b0;
                m_last    = N - 1;
                stray_cnt = 4;
                m_arready = 1'b0;
            end else begin
                if (in_burst) begin
                    m_rvalid  = ($urandom_range(0, 3) != 0);
                    m_rdata   = wq[0];
                    m_arready = 1'b0;
                end else begin
                    m_rvalid  = (stray_cnt > 0) || ($urandom_range(0, 7) == 0);
                    m_rdata   = $urandom;
                    m_arready = ($urandom_range(0, 2) == 0);
                end
                if (stray_cnt > 0) stray_cnt--;
            end

            if (stop_req && !any_pend && !in_burst && !busy) begin
                done = 1'b1;
                break;
            end
        end

        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got busy=%0d in_burst=%0d expected idle", busy, in_burst);
        end
        chk("end_exp_empty", exp_q.size(), 0);
        chk("end_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
